// File: rtl/dice_game_ctrl.sv
// Two-player dice game controller: drives the shared dice block, captures each throw,
// keeps both scores and turn ownership, and latches the winner once TARGET is reached.
module dice_game_ctrl #(
    parameter int MIN_ROLL = 4,
    parameter int TARGET   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic [2:0] throw,
    output logic       roll,
    output logic       turn,
    output logic [5:0] score_a,
    output logic [5:0] score_b,
    output logic       done,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE,
        ROLL,
        SETTLE,
        SCORE,
        DONE
    } state_t;

    localparam logic [3:0] MIN_ROLL_C = 4'(MIN_ROLL);
    localparam logic [5:0] TARGET_C   = 6'(TARGET);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] cap_q, cap_d;
    logic [5:0] score_a_q, score_a_d;
    logic [5:0] score_b_q, score_b_d;
    logic       turn_q, turn_d;
    logic       done_q, done_d;
    logic       winner_q, winner_d;

    logic       own_btn;
    logic [3:0] cnt_inc;
    logic       cap_valid;
    logic [5:0] own_score;
    logic [5:0] new_score;

    function automatic logic [5:0] sat_add6(input logic [5:0] a, input logic [2:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + {4'b0000, b};
        return sum[6] ? 6'd63 : sum[5:0];
    endfunction

    // Only the current owner's button matters; the other player is locked out.
    assign own_btn   = turn_q ? btn_b : btn_a;
    assign cnt_inc   = (cnt_q >= MIN_ROLL_C) ? MIN_ROLL_C : cnt_q + 4'd1;
    assign cap_valid = (cap_q != 3'd0) && (cap_q != 3'd7);
    assign own_score = turn_q ? score_b_q : score_a_q;
    assign new_score = sat_add6(own_score, cap_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cap_q     <= 3'd0;
            score_a_q <= 6'd0;
            score_b_q <= 6'd0;
            turn_q    <= 1'b0;
            done_q    <= 1'b0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            turn_q    <= turn_d;
            done_q    <= done_d;
            winner_q  <= winner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        turn_d    = turn_q;
        done_d    = done_q;
        winner_d  = winner_q;

        case (state_q)
            IDLE: begin
                if (own_btn) begin
                    state_d = ROLL;
                    cnt_d   = 4'd0;
                end
            end
            ROLL: begin
                // An early release keeps the dice spinning until MIN_ROLL cycles have elapsed.
                cnt_d = cnt_inc;
                if (!own_btn && (cnt_inc == MIN_ROLL_C)) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cap_d   = throw;
                state_d = SCORE;
            end
            SCORE: begin
                state_d = IDLE;
                if (cap_valid) begin
                    if (turn_q) begin
                        score_b_d = new_score;
                    end else begin
                        score_a_d = new_score;
                    end
                    if (new_score >= TARGET_C) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        winner_d = turn_q;
                    end else if (cap_q != 3'd6) begin
                        turn_d = ~turn_q;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign roll    = (state_q == ROLL);
    assign turn    = turn_q;
    assign score_a = score_a_q;
    assign score_b = score_b_q;
    assign done    = done_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scenario bench for dice_game_ctrl: expected game state per throw is queued when the
// throw is started and compared once the controller has scored it.
module tb_dice_game_ctrl;

    localparam int MIN_ROLL = 4;
    localparam int TARGET   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic [2:0] throw = 3'd1;
    logic       roll;
    logic       turn;
    logic [5:0] score_a;
    logic [5:0] score_b;
    logic       done;
    logic       winner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] sa;
        logic [5:0] sb;
        logic       t;
        logic       d;
        logic       w;
    } exp_t;

    exp_t sbq[$];

    int   m_sa, m_sb;
    logic m_turn, m_done, m_win;

    dice_game_ctrl #(.MIN_ROLL(MIN_ROLL), .TARGET(TARGET)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_a  (btn_a),
        .btn_b  (btn_b),
        .throw  (throw),
        .roll   (roll),
        .turn   (turn),
        .score_a(score_a),
        .score_b(score_b),
        .done   (done),
        .winner (winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input logic [2:0] v);
        exp_t e;
        int   s;
        if (v >= 3'd1 && v <= 3'd6) begin
            s = (m_turn ? m_sb : m_sa) + int'(v);
            if (s > 63) s = 63;
            if (m_turn) m_sb = s; else m_sa = s;
            if (s >= TARGET) begin
                m_done = 1'b1;
                m_win  = m_turn;
            end else if (v != 3'd6) begin
                m_turn = ~m_turn;
            end
        end
        e.sa = 6'(m_sa);
        e.sb = 6'(m_sb);
        e.t  = m_turn;
        e.d  = m_done;
        e.w  = m_win;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t       e;
        logic [14:0] act, req;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty when a result was produced", name);
        end else begin
            e   = sbq.pop_front();
            act = {score_a, score_b, turn, done, winner};
            req = {e.sa, e.sb, e.t, e.d, e.w};
            if (act !== req) begin
                bad++;
                $display("FAIL %s: got sa=%0d sb=%0d turn=%0b done=%0b win=%0b, want sa=%0d sb=%0d turn=%0b done=%0b win=%0b",
                         name, score_a, score_b, turn, done, winner, e.sa, e.sb, e.t, e.d, e.w);
            end
        end
    endtask

    // Wait for roll to drop, bounded; returns number of extra roll-high samples.
    task automatic wait_roll_low(input string name, output int n);
        int g;
        n = 0;
        g = 0;
        while (roll === 1'b1 && g < 64) begin
            tick();
            g++;
            if (roll === 1'b1) n++;
        end
        if (g >= 64) begin
            total++;
            bad++;
            $display("FAIL %s: roll still high after 64 cycles", name);
        end
    endtask

    task automatic do_throw(input string name, input logic use_b, input int hold,
                            input logic [2:0] v, input logic both);
        int n, extra, want;
        throw = v;
        btn_a = both | ~use_b;
        btn_b = both | use_b;
        push_model(v);
        n = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (roll === 1'b1) n++;
        end
        btn_a = 1'b0;
        btn_b = 1'b0;
        wait_roll_low(name, extra);
        n += extra;
        want = (hold > MIN_ROLL) ? hold : MIN_ROLL;
        total++;
        if (n != want) begin
            bad++;
            $display("FAIL %s_rollcnt: roll high %0d cycles, want %0d", name, n, want);
        end
        tick();
        total++;
        if (roll !== 1'b0) begin
            bad++;
            $display("FAIL %s_settle: roll=%0b in SCORE, want 0", name, roll);
        end
        tick();
        pop_check(name);
    endtask

    task automatic check_no_roll(input string name, input logic pa, input logic pb);
        logic seen;
        seen  = 1'b0;
        btn_a = pa;
        btn_b = pb;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (roll !== 1'b0) seen = 1'b1;
        end
        btn_a = 1'b0;
        btn_b = 1'b0;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL %s: roll went high=%0b, want 0", name, seen);
        end
        push_model(3'd0);
        pop_check({name, "_state"});
    endtask

    task automatic test_reset();
        btn_a = 1'b0;
        btn_b = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        m_sa   = 0;
        m_sb   = 0;
        m_turn = 1'b0;
        m_done = 1'b0;
        m_win  = 1'b0;
        sbq.delete();
        total++;
        if ({roll, turn, score_a, score_b, done, winner} !== 16'd0) begin
            bad++;
            $display("FAIL reset: roll=%0b turn=%0b sa=%0d sb=%0d done=%0b win=%0b, want all 0",
                     roll, turn, score_a, score_b, done, winner);
        end
    endtask

    task automatic test_basic();
        test_reset();
        do_throw("basic_a", 1'b0, 2, 3'd5, 1'b0);
        check_no_roll("basic_b_ignores_a", 1'b1, 1'b0);
        do_throw("basic_b", 1'b1, 1, 3'd2, 1'b0);
    endtask

    task automatic test_hold();
        test_reset();
        do_throw("hold10", 1'b0, 10, 3'd3, 1'b0);
        check_no_roll("hold_a_locked", 1'b1, 1'b0);
    endtask

    task automatic test_bonus();
        test_reset();
        check_no_roll("bonus_b_locked", 1'b0, 1'b1);
        do_throw("bonus6", 1'b0, 2, 3'd6, 1'b0);
        do_throw("bonus_next", 1'b0, 5, 3'd1, 1'b0);
    endtask

    task automatic test_invalid();
        test_reset();
        do_throw("inv7", 1'b0, 2, 3'd7, 1'b0);
        do_throw("inv0", 1'b0, 2, 3'd0, 1'b0);
        do_throw("inv_then2", 1'b0, 2, 3'd2, 1'b0);
        do_throw("both_btn", 1'b1, 2, 3'd4, 1'b1);
    endtask

    task automatic test_win();
        test_reset();
        do_throw("win_a1", 1'b0, 2, 3'd1, 1'b0);
        do_throw("win_b6a", 1'b1, 2, 3'd6, 1'b0);
        do_throw("win_b6b", 1'b1, 2, 3'd6, 1'b0);
        do_throw("win_b5", 1'b1, 2, 3'd5, 1'b0);
        do_throw("win_a1b", 1'b0, 2, 3'd1, 1'b0);
        do_throw("win_b4", 1'b1, 2, 3'd4, 1'b0);
        throw = 3'd6;
        check_no_roll("done_frozen", 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int extra;
        test_reset();
        throw = 3'd6;
        push_model(3'd6);
        btn_a = 1'b1;
        tick();
        tick();
        btn_a = 1'b0;
        wait_roll_low("b2b_first", extra);
        btn_a = 1'b1;
        tick();
        tick();
        total++;
        if (roll !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: roll=%0b in IDLE, want 0", roll);
        end
        pop_check("b2b_first_score");
        push_model(3'd6);
        tick();
        total++;
        if (roll !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: roll=%0b, want 1", roll);
        end
        btn_a = 1'b0;
        wait_roll_low("b2b_second", extra);
        tick();
        tick();
        pop_check("b2b_second_score");
    endtask

    task automatic test_reset_mid_roll();
        test_reset();
        do_throw("mid_a6", 1'b0, 2, 3'd6, 1'b0);
        do_throw("mid_a3", 1'b0, 2, 3'd3, 1'b0);
        do_throw("mid_b1", 1'b1, 2, 3'd1, 1'b0);
        btn_a = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (roll !== 1'b1 || score_a !== 6'd9) begin
            bad++;
            $display("FAIL mid_pre: roll=%0b sa=%0d, want roll=1 sa=9", roll, score_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({roll, turn, score_a, score_b, done, winner} !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: roll=%0b turn=%0b sa=%0d sb=%0d done=%0b win=%0b, want all 0",
                     roll, turn, score_a, score_b, done, winner);
        end
        btn_a = 1'b0;
        tick();
        total++;
        if (roll !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle: roll=%0b, want 0", roll);
        end
        m_sa   = 0;
        m_sb   = 0;
        m_turn = 1'b0;
        m_done = 1'b0;
        m_win  = 1'b0;
        do_throw("mid_after", 1'b0, 2, 3'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_bonus();
        test_invalid();
        test_win();
        test_back_to_back();
        test_reset_mid_roll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
